// File: rtl/npc_axi_pkg.sv
// Shared AXI constants and router state encodings for the core's memory fabric.
package npc_axi_pkg;

    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;

    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] CLINT_MASK = 32'hFFFF_0000;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rstate_e;

    typedef enum logic [2:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP,
        W_DROP,
        W_ERR
    } wstate_e;

endpackage

// File: rtl/axi_region_decode.sv
// Combinational region match: hit when the masked address equals the region base.
module axi_region_decode #(
    parameter logic [31:0] BASE = 32'h0200_0000,
    parameter logic [31:0] MASK = 32'hFFFF_0000
) (
    input  logic [31:0] addr,
    output logic        hit
);

    assign hit = ((addr & MASK) == BASE);

endmodule

// File: rtl/axi_addr_router.sv
// 1-to-2 AXI4 router: arbiter traffic goes to the CLINT (read-only) or the external SoC port.
// State table
//   R_IDLE | read path free, accepting ar
//   R_ADDR | latched ar presented to the selected slave
//   R_DATA | r channel passed through from the selected slave until rlast
//   W_IDLE | write path free, accepting aw
//   W_ADDR | latched aw presented to the external port
//   W_DATA | w channel passed through to the external port until wlast
//   W_RESP | b channel passed through from the external port
//   W_DROP | CLINT write: data beats swallowed until wlast
//   W_ERR  | local SLVERR response for the dropped CLINT write
module axi_addr_router #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
    input  logic                    clock,
    input  logic                    rst,
    // arbiter side
    input  logic                    m_arvalid,
    input  logic [31:0]             m_araddr,
    input  logic [3:0]              m_arid,
    input  logic [7:0]              m_arlen,
    input  logic [2:0]              m_arsize,
    input  logic [1:0]              m_arburst,
    output logic                    m_arready,
    output logic                    m_rvalid,
    output logic [DATA_WIDTH-1:0]   m_rdata,
    output logic [1:0]              m_rresp,
    output logic [3:0]              m_rid,
    output logic                    m_rlast,
    input  logic                    m_rready,
    input  logic                    m_awvalid,
    input  logic [31:0]             m_awaddr,
    input  logic [3:0]              m_awid,
    input  logic [7:0]              m_awlen,
    input  logic [2:0]              m_awsize,
    input  logic [1:0]              m_awburst,
    output logic                    m_awready,
    input  logic                    m_wvalid,
    input  logic [DATA_WIDTH-1:0]   m_wdata,
    input  logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                    m_wlast,
    output logic                    m_wready,
    output logic                    m_bvalid,
    output logic [1:0]              m_bresp,
    output logic [3:0]              m_bid,
    input  logic                    m_bready,
    // external SoC port
    output logic                    x_arvalid,
    output logic [31:0]             x_araddr,
    output logic [3:0]              x_arid,
    output logic [7:0]              x_arlen,
    output logic [2:0]              x_arsize,
    output logic [1:0]              x_arburst,
    input  logic                    x_arready,
    input  logic                    x_rvalid,
    input  logic [DATA_WIDTH-1:0]   x_rdata,
    input  logic [1:0]              x_rresp,
    input  logic [3:0]              x_rid,
    input  logic                    x_rlast,
    output logic                    x_rready,
    output logic                    x_awvalid,
    output logic [31:0]             x_awaddr,
    output logic [3:0]              x_awid,
    output logic [7:0]              x_awlen,
    output logic [2:0]              x_awsize,
    output logic [1:0]              x_awburst,
    input  logic                    x_awready,
    output logic                    x_wvalid,
    output logic [DATA_WIDTH-1:0]   x_wdata,
    output logic [DATA_WIDTH/8-1:0] x_wstrb,
    output logic                    x_wlast,
    input  logic                    x_wready,
    input  logic                    x_bvalid,
    input  logic [1:0]              x_bresp,
    input  logic [3:0]              x_bid,
    output logic                    x_bready,
    // CLINT slave (read only)
    output logic                    c_arvalid,
    output logic [31:0]             c_araddr,
    output logic [3:0]              c_arid,
    output logic [7:0]              c_arlen,
    output logic [2:0]              c_arsize,
    output logic [1:0]              c_arburst,
    input  logic                    c_arready,
    input  logic                    c_rvalid,
    input  logic [DATA_WIDTH-1:0]   c_rdata,
    input  logic [1:0]              c_rresp,
    input  logic [3:0]              c_rid,
    input  logic                    c_rlast,
    output logic                    c_rready
);

    import npc_axi_pkg::*;

    rstate_e     rstate_q, rstate_d;
    wstate_e     wstate_q, wstate_d;

    logic [31:0] ar_addr_q, ar_addr_d;
    logic [3:0]  ar_id_q, ar_id_d;
    logic [7:0]  ar_len_q, ar_len_d;
    logic [2:0]  ar_size_q, ar_size_d;
    logic [1:0]  ar_burst_q, ar_burst_d;
    logic        r_sel_q, r_sel_d;

    logic [31:0] aw_addr_q, aw_addr_d;
    logic [3:0]  aw_id_q, aw_id_d;
    logic [7:0]  aw_len_q, aw_len_d;
    logic [2:0]  aw_size_q, aw_size_d;
    logic [1:0]  aw_burst_q, aw_burst_d;

    logic        ar_hit;
    logic        aw_hit;

    axi_region_decode #(.BASE(CLINT_BASE), .MASK(CLINT_MASK)) u_ar_decode (
        .addr (m_araddr),
        .hit  (ar_hit)
    );

    axi_region_decode #(.BASE(CLINT_BASE), .MASK(CLINT_MASK)) u_aw_decode (
        .addr (m_awaddr),
        .hit  (aw_hit)
    );

    always_ff @(posedge clock) begin
        if (!rst) begin
            rstate_q   <= R_IDLE;
            wstate_q   <= W_IDLE;
            ar_addr_q  <= '0;
            ar_id_q    <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_sel_q    <= 1'b0;
            aw_addr_q  <= '0;
            aw_id_q    <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
        end else begin
            rstate_q   <= rstate_d;
            wstate_q   <= wstate_d;
            ar_addr_q  <= ar_addr_d;
            ar_id_q    <= ar_id_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_sel_q    <= r_sel_d;
            aw_addr_q  <= aw_addr_d;
            aw_id_q    <= aw_id_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
        end
    end

    // Address payload is always driven from the latches so it cannot move while valid is up.
    assign x_araddr  = ar_addr_q;
    assign x_arid    = ar_id_q;
    assign x_arlen   = ar_len_q;
    assign x_arsize  = ar_size_q;
    assign x_arburst = ar_burst_q;
    assign c_araddr  = ar_addr_q;
    assign c_arid    = ar_id_q;
    assign c_arlen   = ar_len_q;
    assign c_arsize  = ar_size_q;
    assign c_arburst = ar_burst_q;
    assign x_awaddr  = aw_addr_q;
    assign x_awid    = aw_id_q;
    assign x_awlen   = aw_len_q;
    assign x_awsize  = aw_size_q;
    assign x_awburst = aw_burst_q;
    assign x_wdata   = m_wdata;
    assign x_wstrb   = m_wstrb;
    assign x_wlast   = m_wlast;

    // r_sel_q: 1 = CLINT, 0 = external
    always_comb begin
        rstate_d   = rstate_q;
        ar_addr_d  = ar_addr_q;
        ar_id_d    = ar_id_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        r_sel_d    = r_sel_q;
        m_arready  = 1'b0;
        x_arvalid  = 1'b0;
        c_arvalid  = 1'b0;
        m_rvalid   = 1'b0;
        m_rdata    = '0;
        m_rresp    = AXI_RESP_OKAY;
        m_rid      = '0;
        m_rlast    = 1'b0;
        x_rready   = 1'b0;
        c_rready   = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                m_arready = 1'b1;
                if (m_arvalid) begin
                    ar_addr_d  = m_araddr;
                    ar_id_d    = m_arid;
                    ar_len_d   = m_arlen;
                    ar_size_d  = m_arsize;
                    ar_burst_d = m_arburst;
                    r_sel_d    = ar_hit;
                    rstate_d   = R_ADDR;
                end
            end
            R_ADDR: begin
                x_arvalid = !r_sel_q;
                c_arvalid = r_sel_q;
                if (r_sel_q ? c_arready : x_arready)
                    rstate_d = R_DATA;
            end
            R_DATA: begin
                if (r_sel_q) begin
                    m_rvalid = c_rvalid;
                    m_rdata  = c_rdata;
                    m_rresp  = c_rresp;
                    m_rid    = c_rid;
                    m_rlast  = c_rlast;
                    c_rready = m_rready;
                end else begin
                    m_rvalid = x_rvalid;
                    m_rdata  = x_rdata;
                    m_rresp  = x_rresp;
                    m_rid    = x_rid;
                    m_rlast  = x_rlast;
                    x_rready = m_rready;
                end
                if (m_rvalid && m_rready && m_rlast)
                    rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        wstate_d   = wstate_q;
        aw_addr_d  = aw_addr_q;
        aw_id_d    = aw_id_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        m_awready  = 1'b0;
        x_awvalid  = 1'b0;
        x_wvalid   = 1'b0;
        m_wready   = 1'b0;
        m_bvalid   = 1'b0;
        m_bresp    = AXI_RESP_OKAY;
        m_bid      = '0;
        x_bready   = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                m_awready = 1'b1;
                if (m_awvalid) begin
                    aw_addr_d  = m_awaddr;
                    aw_id_d    = m_awid;
                    aw_len_d   = m_awlen;
                    aw_size_d  = m_awsize;
                    aw_burst_d = m_awburst;
                    wstate_d   = aw_hit ? W_DROP : W_ADDR;
                end
            end
            W_ADDR: begin
                x_awvalid = 1'b1;
                if (x_awready)
                    wstate_d = W_DATA;
            end
            W_DATA: begin
                x_wvalid = m_wvalid;
                m_wready = x_wready;
                if (m_wvalid && x_wready && m_wlast)
                    wstate_d = W_RESP;
            end
            W_RESP: begin
                m_bvalid = x_bvalid;
                m_bresp  = x_bresp;
                m_bid    = x_bid;
                x_bready = m_bready;
                if (x_bvalid && m_bready)
                    wstate_d = W_IDLE;
            end
            W_DROP: begin
                m_wready = 1'b1;
                if (m_wvalid && m_wlast)
                    wstate_d = W_ERR;
            end
            W_ERR: begin
                m_bvalid = 1'b1;
                m_bresp  = AXI_RESP_SLVERR;
                m_bid    = aw_id_q;
                if (m_bready)
                    wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

endmodule
